// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle MULT/DIV sequencer.
// ALU opcodes match the arithmetic encoding of the shared EX-stage ALU.
package muldiv_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StIter,
    StFixLo,
    StFixHi,
    StDone
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, given the ALU result.
// The ALU operand for the divide subtract is exported so the top can drive it.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] alu_y_i,
  output logic [WIDTH-1:0] rem_sh_o,
  output logic [WIDTH-1:0] nxt_hi_o,
  output logic [WIDTH-1:0] nxt_lo_o
);

  logic [WIDTH-1:0] rem_sh;
  logic             carry;
  logic             take;

  // Kept out of the always_comb below so the ALU feedback path stays acyclic.
  assign rem_sh   = {acc_hi_i[WIDTH-2:0], acc_lo_i[WIDTH-1]};
  assign rem_sh_o = rem_sh;

  always_comb begin
    carry    = alu_y_i < acc_hi_i;
    take     = acc_hi_i[WIDTH-1] | (rem_sh >= opnd_i);
    nxt_hi_o = acc_hi_i;
    nxt_lo_o = acc_lo_i;
    if (is_div_i) begin
      nxt_hi_o = take ? alu_y_i : rem_sh;
      nxt_lo_o = {acc_lo_i[WIDTH-2:0], take};
    end else if (acc_lo_i[0]) begin
      nxt_hi_o = {carry, alu_y_i[WIDTH-1:1]};
      nxt_lo_o = {alu_y_i[0], acc_lo_i[WIDTH-1:1]};
    end else begin
      nxt_hi_o = {1'b0, acc_hi_i[WIDTH-1:1]};
      nxt_lo_o = {acc_hi_i[0], acc_lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; borrows the shared ALU for add/sub
// while busy. Signed ops work on magnitudes and fix up signs afterwards.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y
);

  localparam int unsigned CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             alu_sel_q, alu_sel_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             accept;
  logic             sign_diff;
  logic             fix_hi;
  logic [WIDTH-1:0] fixed_hi;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i (is_div_q),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .alu_y_i  (alu_y),
    .rem_sh_o (rem_sh),
    .nxt_hi_o (step_hi),
    .nxt_lo_o (step_lo)
  );

  // rs is held in opnd for multiply (multiplicand) and in acc_lo for divide (dividend).
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OPW'(ALU_ADD);
    unique case (state_q)
      StNegA: begin
        alu_op = OPW'(ALU_SUB);
        alu_b  = is_div_q ? acc_lo_q : opnd_q;
      end
      StNegB: begin
        alu_op = OPW'(ALU_SUB);
        alu_b  = is_div_q ? opnd_q : acc_lo_q;
      end
      StIter: begin
        alu_op = is_div_q ? OPW'(ALU_SUB) : OPW'(ALU_ADD);
        alu_a  = is_div_q ? rem_sh : acc_hi_q;
        alu_b  = opnd_q;
      end
      StFixLo: begin
        alu_op = OPW'(ALU_SUB);
        alu_b  = acc_lo_q;
      end
      StFixHi: begin
        if (is_div_q) begin
          alu_op = OPW'(ALU_SUB);
          alu_b  = acc_hi_q;
        end else begin
          alu_a = ~acc_hi_q;
          alu_b = {{(WIDTH - 1){1'b0}}, acc_lo_q == '0};
        end
      end
      default: ;
    endcase
  end

  assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
  assign sign_diff = neg_a_q ^ neg_b_q;
  assign fix_hi    = is_div_q ? neg_a_q : sign_diff;
  assign fixed_hi  = fix_hi ? alu_y : acc_hi_q;

  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    neg_a_d     = neg_a_q;
    neg_b_d     = neg_b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opnd_d      = opnd_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          is_div_d    = md_is_div(op);
          is_signed_d = md_is_signed(op);
          neg_a_d     = md_is_signed(op) & rs_val[WIDTH-1];
          neg_b_d     = md_is_signed(op) & rt_val[WIDTH-1];
          acc_hi_d    = '0;
          acc_lo_d    = md_is_div(op) ? rs_val : rt_val;
          opnd_d      = md_is_div(op) ? rt_val : rs_val;
          cnt_d       = '0;
          dbz_d       = 1'b0;
          if (md_is_div(op) && (rt_val == '0)) begin
            state_d = StDone;
            hi_d    = rs_val;
            lo_d    = '1;
            dbz_d   = 1'b1;
          end else begin
            state_d = md_is_signed(op) ? StNegA : StIter;
          end
        end else begin
          state_d = StIdle;
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      StNegA: begin
        if (neg_a_q) begin
          if (is_div_q) acc_lo_d = alu_y;
          else          opnd_d   = alu_y;
        end
        state_d = StNegB;
      end
      StNegB: begin
        if (neg_b_q) begin
          if (is_div_q) opnd_d   = alu_y;
          else          acc_lo_d = alu_y;
        end
        state_d = StIter;
      end
      StIter: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          if (is_signed_q) begin
            state_d = StFixLo;
          end else begin
            state_d = StDone;
            hi_d    = step_hi;
            lo_d    = step_lo;
          end
        end
      end
      StFixLo: begin
        if (sign_diff) acc_lo_d = alu_y;
        state_d = StFixHi;
      end
      StFixHi: begin
        acc_hi_d = fixed_hi;
        hi_d     = fixed_hi;
        lo_d     = acc_lo_q;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_d    = (state_d == StNegA) || (state_d == StNegB) || (state_d == StIter) ||
                (state_d == StFixLo) || (state_d == StFixHi);
    alu_sel_d = busy_d;
    done_d    = state_d == StDone;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alu_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opnd_q      <= opnd_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alu_sel_q   <= alu_sel_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dbz     = dbz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_sel = alu_sel_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with a behavioural add/sub ALU in the feedback loop.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] alu_y;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign alu_y = (alu_op == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);

  muldiv_seq #(
    .WIDTH(WIDTH),
    .OPW  (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .dbz     (dbz),
    .hi      (hi),
    .lo      (lo),
    .alu_sel (alu_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_y   (alu_y)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count busy cycles (sampled at negedge) until done; bounded so a dead DUT cannot hang us.
  task automatic wait_done(input int b0, output int bcyc, output bit seen, output bit add_only);
    bcyc     = b0;
    seen     = 1'b0;
    add_only = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else if (busy) begin
        bcyc++;
        if (alu_op != ALU_ADD) add_only = 1'b0;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int bcyc, output bit seen, output bit add_only);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(0, bcyc, seen, add_only);
  endtask

  int bc;
  bit sd;
  bit ao;
  int done_cnt;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_val  = '0;
    rt_val  = '0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dbz", 64'(dbz), 64'd0);
    check_eq("rst_alu_sel", 64'(alu_sel), 64'd0);
    check_eq("rst_hilo", {hi, lo}, 64'd0);
    check_eq("rst_alu_ab", {alu_a, alu_b}, 64'd0);
    check_eq("rst_alu_op", 64'(alu_op), 64'(ALU_ADD));
    reset = 1'b0;
    @(negedge clk);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, sd, ao);
    check_eq("multu_done", 64'(sd), 64'd1);
    check_eq("multu_busy", 64'(bc), 64'd32);
    check_eq("multu_addonly", 64'(ao), 64'd1);
    check_eq("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, bc, sd, ao);
    check_eq("mult_busy", 64'(bc), 64'd36);
    check_eq("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, bc, sd, ao);
    check_eq("div_busy", 64'(bc), 64'd36);
    check_eq("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MD_DIVU, 32'd100, 32'd7, bc, sd, ao);
    check_eq("divu_busy", 64'(bc), 64'd32);
    check_eq("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    run_op(MD_DIVU, 32'd5, 32'd0, bc, sd, ao);
    check_eq("dbz_done", 64'(sd), 64'd1);
    check_eq("dbz_busy", 64'(bc), 64'd0);
    check_eq("dbz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    check_eq("dbz_flag", 64'(dbz), 64'd1);

    run_op(MD_MULTU, 32'd6, 32'd7, bc, sd, ao);
    check_eq("dbz_clear", 64'(dbz), 64'd0);
    check_eq("mul67_hilo", {hi, lo}, {32'd0, 32'd42});

    // start and mthi during ITER must both be ignored
    start  = 1'b1;
    op     = MD_MULTU;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'd2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    start   = 1'b1;
    op      = MD_DIVU;
    rs_val  = 32'd9;
    rt_val  = 32'd0;
    mthi    = 1'b1;
    wr_data = 32'h1234;
    @(posedge clk);
    #1 start = 1'b0;
    mthi = 1'b0;
    wait_done(9, bc, sd, ao);
    check_eq("ign_done", 64'(sd), 64'd1);
    check_eq("ign_busy", 64'(bc), 64'd32);
    check_eq("ign_hilo", {hi, lo}, {32'd1, 32'hFFFF_FFFE});
    check_eq("ign_dbz", 64'(dbz), 64'd0);

    @(negedge clk);
    mthi    = 1'b1;
    wr_data = 32'h1234;
    @(posedge clk);
    #1 mthi = 1'b0;
    check_eq("mthi_idle", {hi, lo}, {32'h1234, 32'hFFFF_FFFE});
    @(negedge clk);
    mtlo    = 1'b1;
    wr_data = 32'h5678;
    @(posedge clk);
    #1 mtlo = 1'b0;
    check_eq("mtlo_idle", {hi, lo}, {32'h1234, 32'h5678});

    // reset in the middle of ITER
    @(negedge clk);
    start  = 1'b1;
    op     = MD_MULTU;
    rs_val = 32'hFFFF_FFFF;
    rt_val = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstmid_busy", 64'(busy), 64'd0);
    check_eq("rstmid_done", 64'(done), 64'd0);
    check_eq("rstmid_alu_sel", 64'(alu_sel), 64'd0);
    check_eq("rstmid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check_eq("rstmid_quiet", 64'(done_cnt), 64'd0);

    run_op(MD_MULTU, 32'd3, 32'd4, bc, sd, ao);
    check_eq("post_rst_done", 64'(sd), 64'd1);
    check_eq("post_rst_hilo", {hi, lo}, {32'd0, 32'd12});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
